// File: rtl/t5_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, STEP result bits per enabled cycle, sign restored in FIX.
module t5_muldiv #(
  parameter int XLEN = 32,  // 32 or 64
  parameter int STEP = 1    // 1, 2 or 4; must divide XLEN
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic            dstb,
  input  logic            dkil,
  input  logic [2:0]      dfn3,
  input  logic [XLEN-1:0] dop1,
  input  logic [XLEN-1:0] dop2,
  output logic            xbsy,
  output logic            xrdy,
  output logic [XLEN-1:0] xres
);

  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]   N_CNT = CW'(N);
  localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            r_state, w_state_nx;
  logic [CW-1:0]     r_cnt,   w_cnt_nx;
  logic [2*XLEN-1:0] r_acc,   w_acc_nx;
  logic [XLEN-1:0]   r_opb,   w_opb_nx;
  logic [2:0]        r_fn,    w_fn_nx;
  logic              r_neg,   w_neg_nx;
  logic [XLEN-1:0]   r_res,   w_res_nx;
  logic              r_rdy,   w_rdy_nx;
  logic              r_bsy,   w_bsy_nx;

  logic            w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_res;

  // Start-time decode: signedness per op, operand magnitudes, single-edge results.
  always_comb begin
    w_sgn1 = (dfn3 == 3'd1) || (dfn3 == 3'd2) || (dfn3[2] && !dfn3[0]);
    w_sgn2 = (dfn3 == 3'd1) || (dfn3[2] && !dfn3[0]);
    w_neg1 = w_sgn1 && dop1[XLEN-1];
    w_neg2 = w_sgn2 && dop2[XLEN-1];
    w_mag1 = w_neg1 ? -dop1 : dop1;
    w_mag2 = w_neg2 ? -dop2 : dop2;
    w_div0 = dfn3[2] && (dop2 == '0);
    w_ovf  = dfn3[2] && !dfn3[0] && (dop1 == X_MIN) && (dop2 == '1);
    w_special = w_div0 || w_ovf;
    if (w_div0) w_spec_res = dfn3[1] ? dop1 : '1;
    else        w_spec_res = dfn3[1] ? '0 : dop1;
  end

  logic [XLEN:0]     w_mhi;
  logic [XLEN-1:0]   w_mlo;
  logic [XLEN:0]     w_drem;
  logic [XLEN-1:0]   w_dquo;
  logic [2*XLEN-1:0] w_mul_step, w_div_step;

  always_comb begin
    // NOTE: blocking assignments here deliberately chain STEP one-bit stages within
    // a single cycle; only the clocked block below holds state, and it uses <=.
    w_mhi = {1'b0, r_acc[2*XLEN-1:XLEN]};
    w_mlo = r_acc[XLEN-1:0];
    w_drem = {1'b0, r_acc[2*XLEN-1:XLEN]};
    w_dquo = r_acc[XLEN-1:0];
    for (int j = 0; j < STEP; j++) begin
      if (w_mlo[0]) w_mhi = w_mhi + {1'b0, r_opb};
      w_mlo = {w_mhi[0], w_mlo[XLEN-1:1]};
      w_mhi = w_mhi >> 1;
      w_drem = {w_drem[XLEN-1:0], w_dquo[XLEN-1]};
      w_dquo = {w_dquo[XLEN-2:0], 1'b0};
      if (w_drem >= {1'b0, r_opb}) begin
        w_drem    = w_drem - {1'b0, r_opb};
        w_dquo[0] = 1'b1;
      end
    end
    w_mul_step = {w_mhi[XLEN-1:0], w_mlo};
    w_div_step = {w_drem[XLEN-1:0], w_dquo};
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_dsel, w_fix_res;

  // Divide: quotient in the low half, remainder in the high half of the accumulator.
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_dsel = r_fn[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    if (r_fn[2])                w_fix_res = r_neg ? -w_dsel : w_dsel;
    else if (r_fn[1:0] == 2'b00) w_fix_res = w_prod[XLEN-1:0];
    else                        w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which is what keeps this block free of inferred latches.
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_acc_nx   = r_acc;
    w_opb_nx   = r_opb;
    w_fn_nx    = r_fn;
    w_neg_nx   = r_neg;
    w_res_nx   = r_res;
    w_rdy_nx   = 1'b0;
    w_bsy_nx   = r_bsy;
    unique case (r_state)
      S_IDLE: begin
        if (dstb && !dkil) begin
          if (w_special) begin
            w_res_nx = w_spec_res;
            w_rdy_nx = 1'b1;
          end else begin
            w_fn_nx    = dfn3;
            w_neg_nx   = (dfn3[2] && dfn3[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
            w_acc_nx   = dfn3[2] ? {{XLEN{1'b0}}, w_mag1} : {{XLEN{1'b0}}, w_mag2};
            w_opb_nx   = dfn3[2] ? w_mag2 : w_mag1;
            w_cnt_nx   = N_CNT;
            w_bsy_nx   = 1'b1;
            w_state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (dkil) begin
          w_bsy_nx   = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_acc_nx = r_fn[2] ? w_div_step : w_mul_step;
          w_cnt_nx = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_state_nx = S_FIX;
        end
      end
      S_FIX: begin
        w_bsy_nx   = 1'b0;
        w_state_nx = S_IDLE;
        if (!dkil) begin
          w_res_nx = w_fix_res;
          w_rdy_nx = 1'b1;
        end
      end
      default: begin
        w_bsy_nx   = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opb   <= '0;
      r_fn    <= '0;
      r_neg   <= 1'b0;
      r_res   <= '0;
      r_rdy   <= 1'b0;
      r_bsy   <= 1'b0;
    end else if (sena) begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_acc   <= w_acc_nx;
      r_opb   <= w_opb_nx;
      r_fn    <= w_fn_nx;
      r_neg   <= w_neg_nx;
      r_res   <= w_res_nx;
      r_rdy   <= w_rdy_nx;
      r_bsy   <= w_bsy_nx;
    end
  end

  assign xbsy = r_bsy;
  assign xrdy = r_rdy;
  assign xres = r_res;

endmodule

// File: tb/tb_t5_muldiv.sv
// Self-checking bench for t5_muldiv: a 32-bit STEP=1 and a 64-bit STEP=4 instance,
// checked against a plain-arithmetic model of the M-extension operations.
module tb_t5_muldiv;

  logic        sclk = 1'b0;
  logic        srst, sena, dkil, dstb32, dstb64;
  logic [2:0]  dfn3;
  logic [63:0] dop1, dop2;
  logic        xbsy32, xrdy32, xbsy64, xrdy64;
  logic [31:0] xres32;
  logic [63:0] xres64;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] last32 = '0;
  logic [63:0] last64 = '0;

  t5_muldiv #(.XLEN(32), .STEP(1)) u_dut32 (
    .sclk(sclk), .srst(srst), .sena(sena), .dstb(dstb32), .dkil(dkil),
    .dfn3(dfn3), .dop1(dop1[31:0]), .dop2(dop2[31:0]),
    .xbsy(xbsy32), .xrdy(xrdy32), .xres(xres32)
  );

  t5_muldiv #(.XLEN(64), .STEP(4)) u_dut64 (
    .sclk(sclk), .srst(srst), .sena(sena), .dstb(dstb64), .dkil(dkil),
    .dfn3(dfn3), .dop1(dop1), .dop2(dop2),
    .xbsy(xbsy64), .xrdy(xrdy64), .xres(xres64)
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic sample(input bit wide, output logic bsy, output logic rdy,
                        output logic [63:0] res);
    bsy = wide ? xbsy64 : xbsy32;
    rdy = wide ? xrdy64 : xrdy32;
    res = wide ? xres64 : {32'h0, xres32};
  endtask

  function automatic logic [63:0] wmask(input bit wide);
    return wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Reference: exact integer arithmetic on wide signed values, then truncation.
  function automatic logic [63:0] ref_md(input bit wide, input logic [2:0] fn,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] ua, ub, sa, sb, r;
    int w;
    w  = wide ? 64 : 32;
    ua = {66'b0, a & wmask(wide)};
    ub = {66'b0, b & wmask(wide)};
    sa = a[w-1] ? ua - (130'sd1 << w) : ua;
    sb = b[w-1] ? ub - (130'sd1 << w) : ub;
    case (fn)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >>> w;
      3'd4: r = (ub == 0) ? -130'sd1 : sa / sb;
      3'd5: r = (ub == 0) ? -130'sd1 : ua / ub;
      3'd6: r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[63:0] & wmask(wide);
  endfunction

  function automatic bit is_special(input bit wide, input logic [2:0] fn,
                                    input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, mn;
    m  = wmask(wide);
    mn = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (fn[2] && ((b & m) == 64'h0)) return 1'b1;
    if ((fn == 3'd4 || fn == 3'd6) && ((a & m) == mn) && ((b & m) == m)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] pick(input bit wide);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'h0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      3: v = 64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v & wmask(wide);
  endfunction

  // One operation from start strobe to result; optional sena stall and busy-time pokes.
  task automatic run_op(input bit wide, input logic [2:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input string name,
                        input int stall_len = 0, input bit poke = 1'b0);
    int n, lat, busy_cnt, want_lat;
    bit sp;
    logic bsy, rdy;
    logic [63:0] res;
    n = wide ? 16 : 32;
    lat = 0;
    busy_cnt = 0;
    want_lat = n + 1 + stall_len;
    sp = is_special(wide, fn, a, b);
    dfn3 = fn; dop1 = a; dop2 = b;
    if (wide) dstb64 = 1'b1; else dstb32 = 1'b1;
    tick();
    dstb32 = 1'b0; dstb64 = 1'b0;
    dfn3 = 3'($urandom); dop1 = {$urandom, $urandom}; dop2 = {$urandom, $urandom};
    sample(wide, bsy, rdy, res);
    if (sp) begin
      n_checks++;
      if (rdy !== 1'b1 || bsy !== 1'b0) begin
        $display("FAIL %s special strobe: rdy=%b bsy=%b, expected rdy=1 bsy=0", name, rdy, bsy);
        n_errors++;
      end
      n_checks++;
      if (res !== exp) begin
        $display("FAIL %s special result: got %h expected %h", name, res, exp);
        n_errors++;
      end
    end else begin
      n_checks++;
      if (rdy !== 1'b0 || bsy !== 1'b1) begin
        $display("FAIL %s start: rdy=%b bsy=%b, expected rdy=0 bsy=1", name, rdy, bsy);
        n_errors++;
      end
      while (rdy !== 1'b1 && lat < 400) begin
        if (bsy === 1'b1) busy_cnt++;
        sena = !(stall_len > 0 && lat >= 5 && lat < 5 + stall_len);
        if (poke && lat >= 2 && lat <= 5) begin
          dfn3 = 3'($urandom); dop1 = {$urandom, $urandom}; dop2 = {$urandom, $urandom};
          if (wide) dstb64 = 1'b1; else dstb32 = 1'b1;
        end else begin
          dstb32 = 1'b0; dstb64 = 1'b0;
        end
        tick();
        lat++;
        sample(wide, bsy, rdy, res);
      end
      sena = 1'b1; dstb32 = 1'b0; dstb64 = 1'b0;
      n_checks++;
      if (lat != want_lat) begin
        $display("FAIL %s latency: got %0d edges expected %0d", name, lat, want_lat);
        n_errors++;
      end
      n_checks++;
      if (busy_cnt != want_lat) begin
        $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, want_lat);
        n_errors++;
      end
      n_checks++;
      if (res !== exp || bsy !== 1'b0) begin
        $display("FAIL %s result: got %h bsy=%b expected %h bsy=0", name, res, bsy, exp);
        n_errors++;
      end
    end
    if (wide) last64 = exp; else last32 = exp;
  endtask

  task automatic test_reset();
    srst = 1'b1; sena = 1'b0; dkil = 1'b0; dstb32 = 1'b1; dstb64 = 1'b1;
    dfn3 = 3'd0; dop1 = 64'd3; dop2 = 64'd5;
    repeat (3) tick();
    n_checks++;
    if (xbsy32 !== 1'b0 || xrdy32 !== 1'b0 || xres32 !== 32'h0) begin
      $display("FAIL reset32: bsy=%b rdy=%b res=%h expected 0 0 0", xbsy32, xrdy32, xres32);
      n_errors++;
    end
    n_checks++;
    if (xbsy64 !== 1'b0 || xrdy64 !== 1'b0 || xres64 !== 64'h0) begin
      $display("FAIL reset64: bsy=%b rdy=%b res=%h expected 0 0 0", xbsy64, xrdy64, xres64);
      n_errors++;
    end
    srst = 1'b0; sena = 1'b1; dstb32 = 1'b0; dstb64 = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_op(0, 3'd0, 64'h7,        64'hFFFF_FFFD, 64'hFFFF_FFEB, "mul");
    run_op(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "mulh");
    run_op(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhsu");
    run_op(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "mulhu");
    run_op(0, 3'd4, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFD, "div");
    run_op(0, 3'd6, 64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFF, "rem");
    run_op(0, 3'd5, 64'd100,       64'd7,         64'd14,        "divu");
    run_op(0, 3'd7, 64'd100,       64'd7,         64'd2,         "remu");
    run_op(0, 3'd4, 64'd5,         64'd0,         64'hFFFF_FFFF, "div_by0");
    run_op(0, 3'd6, 64'd5,         64'd0,         64'd5,         "rem_by0");
    run_op(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "div_ovf");
    run_op(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         "rem_ovf");
    run_op(1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, "mulhu64_poke", 0, 1'b1);
    run_op(1, 3'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, "div64");
  endtask

  task automatic test_enable();
    logic bsy, rdy;
    logic [63:0] res;
    run_op(0, 3'd0, 64'h7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, "mul_stall", 5);
    sena = 1'b0;
    repeat (3) tick();
    sample(0, bsy, rdy, res);
    n_checks++;
    if (rdy !== 1'b1 || res !== 64'hFFFF_FFEB) begin
      $display("FAIL rdy_hold: rdy=%b res=%h expected rdy=1 res=ffffffeb", rdy, res);
      n_errors++;
    end
    sena = 1'b1;
    tick();
    sample(0, bsy, rdy, res);
    n_checks++;
    if (rdy !== 1'b0 || res !== 64'hFFFF_FFEB) begin
      $display("FAIL rdy_clear: rdy=%b res=%h expected rdy=0 res=ffffffeb", rdy, res);
      n_errors++;
    end
  endtask

  task automatic kill_after(input int edges, input string name);
    bit seen;
    dfn3 = 3'd5; dop1 = {32'h0, $urandom}; dop2 = 64'($urandom_range(1, 1000));
    dstb32 = 1'b1;
    tick();
    dstb32 = 1'b0;
    repeat (edges) tick();
    dkil = 1'b1;
    tick();
    dkil = 1'b0;
    n_checks++;
    if (xbsy32 !== 1'b0 || xrdy32 !== 1'b0 || {32'h0, xres32} !== last32) begin
      $display("FAIL %s: bsy=%b rdy=%b res=%h expected 0 0 %h", name, xbsy32, xrdy32,
               xres32, last32);
      n_errors++;
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (xrdy32 !== 1'b0 || xbsy32 !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      $display("FAIL %s_quiet: activity after kill, expected none", name);
      n_errors++;
    end
  endtask

  task automatic test_kill();
    kill_after(10, "kill_run");
    kill_after(32, "kill_fix");
    dfn3 = 3'd0; dop1 = 64'd3; dop2 = 64'd4; dstb32 = 1'b1; dkil = 1'b1;
    tick();
    dstb32 = 1'b0; dkil = 1'b0;
    n_checks++;
    if (xbsy32 !== 1'b0 || xrdy32 !== 1'b0) begin
      $display("FAIL kill_idle: bsy=%b rdy=%b expected 0 0", xbsy32, xrdy32);
      n_errors++;
    end
    run_op(0, 3'd3, 64'h1234_5678, 64'h9ABC_DEF0, ref_md(0, 3'd3, 64'h1234_5678,
           64'h9ABC_DEF0), "after_kill");
  endtask

  task automatic test_srst_mid();
    bit seen;
    dfn3 = 3'd0; dop1 = 64'd9; dop2 = 64'd9; dstb32 = 1'b1;
    tick();
    dstb32 = 1'b0;
    repeat (10) tick();
    srst = 1'b1; sena = 1'b0; dkil = 1'b1;
    tick();
    srst = 1'b0; sena = 1'b1; dkil = 1'b0;
    last32 = '0;
    n_checks++;
    if (xbsy32 !== 1'b0 || xrdy32 !== 1'b0 || xres32 !== 32'h0) begin
      $display("FAIL srst_mid: bsy=%b rdy=%b res=%h expected 0 0 0", xbsy32, xrdy32, xres32);
      n_errors++;
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (xrdy32 !== 1'b0 || xbsy32 !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      $display("FAIL srst_quiet: activity after reset, expected none");
      n_errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b;
    a = {32'h0, $urandom}; b = {32'h0, $urandom};
    run_op(0, 3'd1, a, b, ref_md(0, 3'd1, a, b), "b2b_first");
    a = {32'h0, $urandom}; b = 64'($urandom_range(1, 50));
    run_op(0, 3'd6, a, b, ref_md(0, 3'd6, a, b), "b2b_second");
    run_op(0, 3'd5, a, 64'h0, 64'hFFFF_FFFF, "b2b_spec1");
    run_op(0, 3'd7, 64'd77, 64'h0, 64'd77, "b2b_spec2");
    run_op(0, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1, "b2b_after_spec");
  endtask

  task automatic test_random();
    logic [2:0] fn;
    logic [63:0] a, b;
    for (int i = 0; i < 30; i++) begin
      fn = 3'($urandom); a = pick(0); b = pick(0);
      run_op(0, fn, a, b, ref_md(0, fn, a, b), "rand32");
    end
    for (int i = 0; i < 12; i++) begin
      fn = 3'($urandom); a = pick(1); b = pick(1);
      run_op(1, fn, a, b, ref_md(1, fn, a, b), "rand64");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_enable();
    test_kill();
    test_srst_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
